// File: rtl/emu_system.sv
// Emulation shell: deterministic target (cyc/acc/lfsr + 64-bit RAM) with
// run/pause gating, a 3-word FF scan chain and a pointer-driven RAM scan port.
module emu_system #(
    parameter int MEM_AW    = 4,
    parameter int MEM_DEPTH = 16
) (
    input  logic              host_clk,
    input  logic              target_reset_reset,
    input  logic              run_mode,
    input  logic              scan_mode,
    input  logic              ff_se,
    input  logic [63:0]       ff_di,
    output logic [63:0]       ff_do,
    input  logic              ram_sr,
    input  logic              ram_se,
    input  logic              ram_sd,
    input  logic [63:0]       ram_di,
    output logic [63:0]       ram_do,
    output logic              trc_wen,
    output logic [MEM_AW-1:0] trc_waddr,
    output logic [63:0]       trc_wdata
);

    logic [63:0]       cyc_q, cyc_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       lfsr_q, lfsr_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [63:0]       mem_q [MEM_DEPTH];

    logic              ten;
    logic              ff_shift;
    logic              ram_step;
    logic              ram_wr;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [63:0]       mem_wdata;
    logic [MEM_AW-1:0] idx;
    logic [63:0]       nacc;
    logic              lfsr_fb;

    assign ten      = run_mode & ~scan_mode;
    assign ff_shift = scan_mode & ff_se;
    assign ram_step = scan_mode & ram_se & ~ram_sr;
    assign ram_wr   = ram_step & ram_sd;

    assign idx     = cyc_q[MEM_AW-1:0];
    assign nacc    = acc_q + mem_q[idx] + lfsr_q;
    assign lfsr_fb = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];

    assign trc_wen   = ten;
    assign trc_waddr = idx;
    assign trc_wdata = nacc;

    assign ff_do  = cyc_q;
    assign ram_do = mem_q[ptr_q];

    // ten and ff_shift are mutually exclusive, so they share the state regs
    always_comb begin
        cyc_d  = cyc_q;
        acc_d  = acc_q;
        lfsr_d = lfsr_q;
        ptr_d  = ptr_q;
        if (ten) begin
            cyc_d  = cyc_q + 64'd1;
            acc_d  = nacc;
            lfsr_d = {lfsr_q[62:0], lfsr_fb};
        end else if (ff_shift) begin
            cyc_d  = acc_q;
            acc_d  = lfsr_q;
            lfsr_d = ff_di;
        end
        if (scan_mode & ram_sr) begin
            ptr_d = '0;
        end else if (ram_step) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge host_clk) begin
        if (!target_reset_reset) begin
            cyc_q  <= 64'd0;
            acc_q  <= 64'd0;
            lfsr_q <= 64'd1;
            ptr_q  <= '0;
        end else begin
            cyc_q  <= cyc_d;
            acc_q  <= acc_d;
            lfsr_q <= lfsr_d;
            ptr_q  <= ptr_d;
        end
    end

    // RAM has no reset; the target and the scan port share one write port
    assign mem_we    = target_reset_reset & (ten | ram_wr);
    assign mem_waddr = ten ? idx : ptr_q;
    assign mem_wdata = ten ? nacc : ram_di;

    always_ff @(posedge host_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_emu_system.sv
// Directed bench for emu_system: reference model feeds a trace scoreboard,
// scan dumps/loads are checked against the model, checkpoint/restore replays.
module tb_emu_system;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_mode, scan_mode;
    logic        ff_se;
    logic [63:0] ff_di, ff_do;
    logic        ram_sr, ram_se, ram_sd;
    logic [63:0] ram_di, ram_do;
    logic        trc_wen;
    logic [3:0]  trc_waddr;
    logic [63:0] trc_wdata;

    always #5 clk = ~clk;

    emu_system dut (
        .host_clk          (clk),
        .target_reset_reset(rst_n),
        .run_mode          (run_mode),
        .scan_mode         (scan_mode),
        .ff_se             (ff_se),
        .ff_di             (ff_di),
        .ff_do             (ff_do),
        .ram_sr            (ram_sr),
        .ram_se            (ram_se),
        .ram_sd            (ram_sd),
        .ram_di            (ram_di),
        .ram_do            (ram_do),
        .trc_wen           (trc_wen),
        .trc_waddr         (trc_waddr),
        .trc_wdata         (trc_wdata)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [63:0] d;
    } trc_t;

    trc_t        sbq[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    logic [63:0] m_cyc, m_acc, m_lfsr;
    logic [63:0] m_mem[16];
    logic [3:0]  m_ptr;
    logic [63:0] s_cyc, s_acc, s_lfsr;
    logic [63:0] s_mem[16];
    logic [63:0] dbuf[16];
    logic [63:0] fbuf[3];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_cyc  = 64'd0;
        m_acc  = 64'd0;
        m_lfsr = 64'd1;
        m_ptr  = 4'd0;
    endtask

    task automatic m_step();
        logic [3:0]  i;
        logic [63:0] n;
        trc_t        t;
        i      = m_cyc[3:0];
        n      = m_acc + m_mem[i] + m_lfsr;
        t.a    = i;
        t.d    = n;
        sbq.push_back(t);
        m_mem[i] = n;
        m_acc  = n;
        m_cyc  = m_cyc + 64'd1;
        m_lfsr = {m_lfsr[62:0],
                  m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
    endtask

    // scan-side controls are randomised to prove they are ignored outside scan
    task automatic run1();
        trc_t t;
        run_mode  = 1'b1;
        scan_mode = 1'b0;
        ff_se     = 1'($urandom_range(0, 1));
        ram_se    = 1'($urandom_range(0, 1));
        ram_sr    = 1'($urandom_range(0, 1));
        ram_sd    = 1'($urandom_range(0, 1));
        ff_di     = {$urandom, $urandom};
        ram_di    = {$urandom, $urandom};
        m_step();
        @(negedge clk);
        t = sbq.pop_front();
        chk("trc_wen", 64'(trc_wen), 64'd1);
        chk("trc_waddr", 64'(trc_waddr), 64'(t.a));
        chk("trc_wdata", trc_wdata, t.d);
        tick();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run1();
    endtask

    task automatic scan_idle();
        scan_mode = 1'b1;
        run_mode  = 1'($urandom_range(0, 1));
        ff_se     = 1'b0;
        ram_se    = 1'b0;
        ram_sr    = 1'b0;
        ram_sd    = 1'b0;
    endtask

    task automatic ff_dump();
        logic [63:0] w[3];
        int          k = 0;
        int          guard = 0;
        w[0] = m_cyc;
        w[1] = m_acc;
        w[2] = m_lfsr;
        scan_idle();
        while (k < 3 && guard < 100) begin
            ff_se = 1'($urandom_range(0, 1));
            ff_di = ff_do;
            @(negedge clk);
            chk("scan_trc_wen", 64'(trc_wen), 64'd0);
            if (ff_se) begin
                chk("ff_dump", ff_do, w[k]);
                fbuf[k] = ff_do;
                k++;
            end
            tick();
            guard++;
        end
        if (k < 3) chk("ff_dump_timeout", 64'(k), 64'd3);
        ff_se = 1'b0;
        @(negedge clk);
        chk("ff_loop_restored", ff_do, m_cyc);
        tick();
    endtask

    task automatic ff_load();
        scan_idle();
        for (int k = 0; k < 3; k++) begin
            ff_se = 1'b1;
            ff_di = fbuf[k];
            tick();
        end
        ff_se = 1'b0;
    endtask

    task automatic ram_rst();
        scan_idle();
        ram_sr = 1'b1;
        ram_se = 1'($urandom_range(0, 1));
        ram_sd = 1'b1;
        ram_di = 64'hFFFF_0000_FFFF_0000;
        tick();
        ram_sr = 1'b0;
        ram_se = 1'b0;
        ram_sd = 1'b0;
        m_ptr  = 4'd0;
    endtask

    task automatic ram_scan(input bit load, input logic [63:0] val,
                            input bit use_buf, input bit gaps);
        int k = 0;
        int guard = 0;
        scan_idle();
        while (k < 16 && guard < 200) begin
            ram_se = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ram_sd = load;
            ram_di = use_buf ? dbuf[m_ptr] : val;
            @(negedge clk);
            if (ram_se) begin
                if (load) begin
                    m_mem[m_ptr] = ram_di;
                end else begin
                    chk("ram_dump", ram_do, m_mem[m_ptr]);
                    dbuf[m_ptr] = ram_do;
                end
                m_ptr = m_ptr + 4'd1;
                k++;
            end
            tick();
            guard++;
        end
        if (k < 16) chk("ram_scan_timeout", 64'(k), 64'd16);
        ram_se = 1'b0;
        ram_sd = 1'b0;
        @(negedge clk);
        chk("ram_ptr_wrap", ram_do, m_mem[0]);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        run_mode  = 1'b0;
        scan_mode = 1'b0;
        ff_se     = 1'b0;
        ff_di     = 64'd0;
        ram_sr    = 1'b0;
        ram_se    = 1'b0;
        ram_sd    = 1'b0;
        ram_di    = 64'd0;
        foreach (m_mem[i]) m_mem[i] = 64'd0;
        m_reset();
        tick();
        tick();
        @(negedge clk);
        chk("rst_ff_do", ff_do, 64'd0);
        chk("rst_trc_wen", 64'(trc_wen), 64'd0);
        tick();
        rst_n = 1'b1;

        // configuration-time RAM clear through the scan port
        ram_rst();
        ram_scan(1'b1, 64'd0, 1'b0, 1'b0);

        run_n(3);
        ff_dump();
        chk("ff_w0_lit", fbuf[0], 64'd3);
        chk("ff_w1_lit", fbuf[1], 64'd7);
        chk("ff_w2_lit", fbuf[2], 64'd8);

        ram_rst();
        ram_scan(1'b0, 64'd0, 1'b0, 1'b1);
        chk("mem0_lit", dbuf[0], 64'd1);
        chk("mem1_lit", dbuf[1], 64'd3);
        chk("mem2_lit", dbuf[2], 64'd7);
        chk("mem15_lit", dbuf[15], 64'd0);

        ram_rst();
        ram_scan(1'b1, 64'h5, 1'b0, 1'b1);
        ram_rst();
        ram_scan(1'b0, 64'd0, 1'b0, 1'b1);
        chk("load5_lit", dbuf[9], 64'h5);

        // leaving scan: target resumes on the first enabled edge
        run_n(497);
        chk("model_at_500", m_cyc, 64'd500);
        ff_dump();
        ram_rst();
        ram_scan(1'b0, 64'd0, 1'b0, 1'b1);
        s_cyc  = m_cyc;
        s_acc  = m_acc;
        s_lfsr = m_lfsr;
        foreach (s_mem[i]) s_mem[i] = m_mem[i];

        run_n(1500);

        ff_load();
        ram_rst();
        ram_scan(1'b1, 64'd0, 1'b1, 1'b1);
        m_cyc  = s_cyc;
        m_acc  = s_acc;
        m_lfsr = s_lfsr;
        foreach (m_mem[i]) m_mem[i] = s_mem[i];
        @(negedge clk);
        chk("restore_ff_do", ff_do, s_cyc);
        tick();
        run_n(200);

        // reset while both scans are active, with a load pending at ptr=5
        ram_rst();
        for (int i = 0; i < 5; i++) begin
            ram_se = 1'b1;
            tick();
        end
        ram_se = 1'b0;
        m_ptr  = 4'd5;
        @(negedge clk);
        chk("ptr5_ram_do", ram_do, m_mem[5]);
        tick();
        rst_n    = 1'b0;
        ff_se    = 1'b1;
        ff_di    = 64'hDEAD_BEEF_0BAD_F00D;
        ram_se   = 1'b1;
        ram_sd   = 1'b1;
        ram_di   = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        rst_n  = 1'b1;
        ff_se  = 1'b0;
        ram_se = 1'b0;
        ram_sd = 1'b0;
        m_reset();
        @(negedge clk);
        chk("midscan_rst_ff_do", ff_do, 64'd0);
        chk("midscan_rst_ptr", ram_do, m_mem[0]);
        tick();
        run_n(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/emu_system.md
# emu_system

Emulation shell around a small deterministic target: target state registers plus a 64-bit-wide RAM. It adds run/pause control, a 64-bit flip-flop (FF) scan chain and a RAM scan port, so the host can checkpoint target state and later restore it. After a restore, the target replays cycle-exactly. It sits between the host checkpoint controller and the target logic; the target's trace port lets the bench compare it against a free-running reference copy.

## Interface
Parameters:
- MEM_AW, default 4: RAM address width.
- MEM_DEPTH, default 16: RAM word count, always 2^MEM_AW.

Ports:
- host_clk  in  1  single system clock, rising edge.
- target_reset_reset  in  1  reset, synchronous, active-low.
- run_mode  in  1  target may advance.
- scan_mode  in  1  scan operations enabled.
- ff_se  in  1  FF chain shift enable.
- ff_di  in  64  FF chain serial word in.
- ff_do  out  64  FF chain serial word out (chain head).
- ram_sr  in  1  RAM scan pointer reset.
- ram_se  in  1  RAM scan step enable.
- ram_sd  in  1  RAM scan direction: 0 = dump, 1 = load.
- ram_di  in  64  RAM load word.
- ram_do  out  64  RAM dump word.
- trc_wen  out  1  target wrote RAM this cycle.
- trc_waddr  out  MEM_AW  trace write address.
- trc_wdata  out  64  trace write data.

## Operation
- Target enable: `ten = run_mode & ~scan_mode`. Clock gating is implemented as a clock enable only; there is no gated clock.
- Target state:
  - `cyc` [63:0], reset 0.
  - `acc` [63:0], reset 0.
  - `lfsr` [63:0], reset 64'h1.
  - `mem[MEM_DEPTH]` x 64. Memory is initialised to 0 at configuration and is never cleared by reset.
- Each cycle with `ten=1`:
  - `idx = cyc[MEM_AW-1:0]`.
  - `nacc = acc + mem[idx] + lfsr`, taken mod 2^64.
  - `mem[idx] <= nacc`, `acc <= nacc`, `cyc <= cyc+1`.
  - `lfsr <= {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}`.
- Trace outputs are combinational:
  - `trc_wen = ten`.
  - `trc_waddr = idx`.
  - `trc_wdata = nacc`.
- FF chain: 3 words. word0 = `cyc`, word1 = `acc`, word2 = `lfsr`.
  - `ff_do = word0` (combinational).
  - On a cycle with `scan_mode & ff_se`: word0 <= word1, word1 <= word2, word2 <= `ff_di`.
  - Dump: sample `ff_do` on each shift cycle, giving word0, word1, word2 in that order. With `ff_di` looped from `ff_do`, the state is unchanged after 3 shifts.
  - Load: present the words in order 0, 1, 2 on `ff_di` on consecutive shift cycles.
  - `ff_se=0` stalls the chain; this is the backpressure mechanism.
- RAM scan: internal pointer `ptr` [MEM_AW-1:0].
  - `scan_mode & ram_sr` sets `ptr` to 0. `ram_sr` has priority over `ram_se`.
  - `ram_do = mem[ptr]` (combinational).
  - On a cycle with `scan_mode & ram_se & ~ram_sr`: if `ram_sd=1`, `mem[ptr] <= ram_di`. `ptr` increments in both directions.
  - `ptr` wraps from MEM_DEPTH-1 to 0.
- With `scan_mode=0`, ff_se, ram_se and ram_sr are ignored.
- Reset (target_reset_reset=0 at the clock edge) sets `cyc`, `acc`, `lfsr` and `ptr` to their reset values and blocks target advance and RAM writes that cycle.
- FF and RAM scans are independent and may be active in the same cycle.

## Timing
- Target update, FF shift, RAM write and ptr step all take effect at the same rising edge. There is 1-cycle visibility on `ff_do` and `ram_do`.
- `ram_do` is valid in the same cycle `ptr` changes, after the edge.
- Reset output values: `ff_do` = 0, `trc_wdata` = 1 when `ten=1`, `ram_do` = mem[0].
- `run_mode=1` together with `scan_mode=1`: the target holds and scan works.
- Leaving scan: the target resumes on the first edge with `ten=1`.

## Test plan
- Reset then run 3 cycles: trace shows waddr/wdata 0/1, 1/3, 2/7. After that, `cyc=3`, `acc=7`, `lfsr=8`, mem[0..2] = 1, 3, 7.
- Pause at cyc=3, assert scan_mode, loop `ff_do` to `ff_di`, shift 3 times with random `ff_se` gaps: dumped words are 3, 7, 8, and the state is unchanged afterwards.
- Pulse ram_sr, dump 16 words with random `ram_se` gaps: returns 1, 3, 7 followed by 13 zeros, and `ptr` wraps to 0.
- Load mem all 64'h5 via ram_sd=1, then read back: 16 × 5.
- Checkpoint at cyc=500, run to 2000, restore the FF chain and RAM from the checkpoint, resume: the trace equals a fresh reference run from cycle 500 onward.
- Assert reset mid-scan: ptr=0 and `ff_do` = 0 next cycle.
